// File: rtl/curr_ctrl_dbg_pkg.sv
// Shared types and constants for the current-control debug capture engine.
package curr_ctrl_dbg_pkg;

    localparam int DBG_ADDR_W  = 9;
    localparam int DBG_DATA_W  = 32;
    localparam int DBG_DECIM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } cap_state_e;

endpackage : curr_ctrl_dbg_pkg

// File: rtl/curr_ctrl_dbg_decim.sv
// Sample qualifier: keeps 1 of every (decim+1) samples and holds a trigger that
// lands on a skipped sample until the next kept one.
module curr_ctrl_dbg_decim
    import curr_ctrl_dbg_pkg::*;
#(
    parameter int DECIM_W = DBG_DECIM_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr_i,
    input  logic               active_i,
    input  logic [DECIM_W-1:0] decim_i,
    input  logic               smp_valid_i,
    input  logic               trig_i,
    output logic               keep_o,
    output logic               trig_o
);

    logic [DECIM_W-1:0] cnt_q;
    logic               pend_q;

    // A zero count means the current sample is kept, so the first sample after clear is kept.
    assign keep_o = smp_valid_i & (cnt_q == {DECIM_W{1'b0}});
    assign trig_o = keep_o & (trig_i | pend_q);

    // Decimation down-counter and pending-trigger flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= {DECIM_W{1'b0}};
            pend_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= {DECIM_W{1'b0}};
            pend_q <= 1'b0;
        end else if (smp_valid_i) begin
            if (keep_o) begin
                cnt_q  <= decim_i;
                pend_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_q - 1'b1;
                pend_q <= pend_q | (active_i & trig_i);
            end
        end else begin
            cnt_q  <= cnt_q;
            pend_q <= pend_q;
        end
    end

endmodule : curr_ctrl_dbg_decim

// File: rtl/curr_ctrl_debug_capture.sv
// Pre/post-trigger circular capture engine driving write port 2 of the debug RAM.
// Optional decimation of incoming samples is compiled in with CURRCTRL_DBG_DECIM_EN.
module curr_ctrl_debug_capture
    import curr_ctrl_dbg_pkg::*;
#(
    parameter int ADDR_W  = DBG_ADDR_W,
    parameter int DATA_W  = DBG_DATA_W,
    parameter int DECIM_W = DBG_DECIM_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                arm,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   post_len,
    input  logic [DECIM_W-1:0]  decim,
    input  logic                smp_valid,
    input  logic [DATA_W-1:0]   smp_data,
    input  logic                trig,
    output logic [ADDR_W-1:0]   address2,
    output logic                chipselect2,
    output logic                write2,
    output logic [DATA_W/8-1:0] byteenable2,
    output logic [DATA_W-1:0]   writedata2,
    output logic                clken2,
    output logic [ADDR_W-1:0]   trig_addr,
    output logic                wrapped,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    cap_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] plen_q;
    logic [ADDR_W-1:0] address2_q;
    logic [DATA_W-1:0] writedata2_q;
    logic              write2_q;
    logic              clken2_q;
    logic [ADDR_W-1:0] trig_addr_q;
    logic              wrapped_q;
    logic              busy_q;
    logic              done_q;

    logic              acc_s;
    logic              trg_s;
    logic              wr_fire_d;
    logic              trig_fire_d;
    logic              post_end_d;

`ifdef CURRCTRL_DBG_DECIM_EN
    curr_ctrl_dbg_decim #(
        .DECIM_W (DECIM_W)
    ) u_decim (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (arm | abort),
        .active_i    (state_q == ST_ARMED),
        .decim_i     (decim),
        .smp_valid_i (smp_valid),
        .trig_i      (trig),
        .keep_o      (acc_s),
        .trig_o      (trg_s)
    );
`else
    logic unused_decim_s;
    assign unused_decim_s = ^decim;
    assign acc_s          = smp_valid;
    assign trg_s          = trig;
`endif

    // Decide whether this cycle's sample is written and whether it is the trigger; arm/abort drop it.
    always_comb begin
        wr_fire_d   = 1'b0;
        trig_fire_d = 1'b0;
        post_end_d  = 1'b0;
        if (abort || arm) begin
            wr_fire_d = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    wr_fire_d   = acc_s;
                    trig_fire_d = acc_s & trg_s;
                end
                ST_POST: begin
                    post_end_d = (cnt_q == plen_q);
                    wr_fire_d  = acc_s & (cnt_q != plen_q);
                end
                default: begin
                    wr_fire_d = 1'b0;
                end
            endcase
        end
    end

    // Capture FSM, write pointer and registered RAM port / status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= {ADDR_W{1'b0}};
            cnt_q        <= {ADDR_W{1'b0}};
            plen_q       <= {ADDR_W{1'b0}};
            address2_q   <= {ADDR_W{1'b0}};
            writedata2_q <= {DATA_W{1'b0}};
            write2_q     <= 1'b0;
            clken2_q     <= 1'b1;
            trig_addr_q  <= {ADDR_W{1'b0}};
            wrapped_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            clken2_q <= 1'b1;
            write2_q <= wr_fire_d;
            if (abort) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (arm) begin
                state_q   <= ST_ARMED;
                ptr_q     <= {ADDR_W{1'b0}};
                cnt_q     <= {ADDR_W{1'b0}};
                wrapped_q <= 1'b0;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
            end else begin
                if (wr_fire_d) begin
                    address2_q   <= ptr_q;
                    writedata2_q <= smp_data;
                    ptr_q        <= ptr_q + 1'b1;
                    if (ptr_q == PTR_MAX) begin
                        wrapped_q <= 1'b1;
                    end
                end
                case (state_q)
                    ST_ARMED: begin
                        if (trig_fire_d) begin
                            // post_len cannot exceed DEPTH-1 by width, so the trigger word survives.
                            trig_addr_q <= ptr_q;
                            cnt_q       <= {ADDR_W{1'b0}};
                            plen_q      <= post_len;
                            state_q     <= ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (post_end_d) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (wr_fire_d) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign address2    = address2_q;
    assign chipselect2 = write2_q;
    assign write2      = write2_q;
    assign byteenable2 = {(DATA_W/8){1'b1}};
    assign writedata2  = writedata2_q;
    assign clken2      = clken2_q;
    assign trig_addr   = trig_addr_q;
    assign wrapped     = wrapped_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule : curr_ctrl_debug_capture

// File: tb/tb_curr_ctrl_debug_capture.sv
// Directed self-checking bench for curr_ctrl_debug_capture with a port-2 RAM model.
module tb_curr_ctrl_debug_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        arm;
    logic        abort;
    logic [8:0]  post_len;
    logic [7:0]  decim;
    logic        smp_valid;
    logic [31:0] smp_data;
    logic        trig;
    logic [8:0]  address2;
    logic        chipselect2;
    logic        write2;
    logic [3:0]  byteenable2;
    logic [31:0] writedata2;
    logic        clken2;
    logic [8:0]  trig_addr;
    logic        wrapped;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          base;
    logic [31:0] ram [0:511];

    curr_ctrl_debug_capture dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .arm         (arm),
        .abort       (abort),
        .post_len    (post_len),
        .decim       (decim),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .trig        (trig),
        .address2    (address2),
        .chipselect2 (chipselect2),
        .write2      (write2),
        .byteenable2 (byteenable2),
        .writedata2  (writedata2),
        .clken2      (clken2),
        .trig_addr   (trig_addr),
        .wrapped     (wrapped),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // RAM model: records every write seen mid-cycle on port 2.
    always @(negedge clk) begin
        if (reset_n && chipselect2 && write2) begin
            ram[address2] <= writedata2;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic sample(input logic [31:0] d, input logic t);
        smp_valid = 1'b1;
        smp_data  = d;
        trig      = t;
        tick();
        smp_valid = 1'b0;
        trig      = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
        post_len  = 9'd0;
        decim     = 8'd0;
        smp_valid = 1'b0;
        smp_data  = 32'd0;
        trig      = 1'b0;
        repeat (2) tick();

        // Reset values
        chk("rst_write2", write2, 1'b0);
        chk("rst_cs2", chipselect2, 1'b0);
        chk("rst_addr2", address2, 9'd0);
        chk("rst_wdata2", writedata2, 32'd0);
        chk("rst_clken2", clken2, 1'b1);
        chk("rst_be2", byteenable2, 4'hF);
        chk("rst_trig_addr", trig_addr, 9'd0);
        chk("rst_status", {wrapped, busy, done}, 3'b000);
        reset_n = 1'b1;
        tick();

        // Basic capture: 5 samples, trigger on the third, post_len=2
        post_len = 9'd2;
        base = wr_cnt;
        pulse_arm();
        chk("a_busy", busy, 1'b1);
        sample(32'hA0, 1'b0);
        chk("a_w0", {write2, chipselect2, address2, writedata2}, {1'b1, 1'b1, 9'd0, 32'hA0});
        sample(32'hA1, 1'b0);
        sample(32'hA2, 1'b1);
        chk("a_trig_addr", trig_addr, 9'd2);
        sample(32'hA3, 1'b0);
        sample(32'hA4, 1'b0);
        chk("a_w4", {write2, address2, writedata2}, {1'b1, 9'd4, 32'hA4});
        chk("a_done_early", done, 1'b0);
        tick();
        chk("a_done", {done, busy, write2}, 3'b100);
        chk("a_wrapped", wrapped, 1'b0);
        chk("a_nwr", 64'(wr_cnt - base), 64'd5);
        chk("a_ram2", ram[2], 32'hA2);
        chk("a_ram4", ram[4], 32'hA4);
        sample(32'hEE, 1'b1);
        tick();
        chk("a_done_drop", 64'(wr_cnt - base), 64'd5);

        // Long run: 600 samples wrap, then trigger with post_len=511
        post_len = 9'd511;
        base = wr_cnt;
        pulse_arm();
        chk("b_flags_clear", {wrapped, done}, 2'b00);
        for (int i = 0; i < 600; i++) begin
            sample(32'(i), 1'b0);
        end
        chk("b_last_addr", address2, 9'd87);
        chk("b_state", {wrapped, busy, done}, 3'b110);
        sample(32'd600, 1'b1);
        chk("b_trig_wr_addr", address2, 9'd88);
        chk("b_trig_addr", trig_addr, 9'd88);
        for (int j = 0; j < 511; j++) begin
            sample(32'(1000 + j), 1'b0);
        end
        chk("b_post_last_addr", address2, 9'd87);
        chk("b_not_done", done, 1'b0);
        tick();
        chk("b_done", {done, busy}, 2'b10);
        chk("b_nwr", 64'(wr_cnt - base), 64'd1112);
        chk("b_ram_trig", ram[88], 32'd600);
        chk("b_ram_first_post", ram[89], 32'd1000);
        chk("b_ram_last_post", ram[87], 32'd1510);

        // arm+trig together restarts capture; abort+arm goes idle
        post_len = 9'd3;
        pulse_arm();
        sample(32'hB0, 1'b0);
        sample(32'hB1, 1'b0);
        chk("c_pre_addr", address2, 9'd1);
        arm = 1'b1; smp_valid = 1'b1; trig = 1'b1; smp_data = 32'hC0;
        tick();
        arm = 1'b0; smp_valid = 1'b0; trig = 1'b0;
        chk("c_busy", {busy, done}, 2'b10);
        chk("c_trig_keep", trig_addr, 9'd88);
        sample(32'hC1, 1'b0);
        chk("c_restart_addr", {address2, writedata2}, {9'd0, 32'hC1});
        chk("c_trig_keep2", trig_addr, 9'd88);
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        chk("c_abort_idle", {busy, done}, 2'b00);
        base = wr_cnt;
        sample(32'hC2, 1'b1);
        sample(32'hC3, 1'b0);
        tick();
        chk("c_no_wr", 64'(wr_cnt - base), 64'd0);
        chk("c_trig_keep3", trig_addr, 9'd88);

        // post_len=0: trigger sample alone
        post_len = 9'd0;
        pulse_arm();
        base = wr_cnt;
        sample(32'hD0, 1'b1);
        chk("d_w0", {write2, address2, writedata2}, {1'b1, 9'd0, 32'hD0});
        chk("d_not_done", done, 1'b0);
        sample(32'hD1, 1'b0);
        chk("d_done", {done, write2}, 2'b10);
        chk("d_trig_addr", trig_addr, 9'd0);
        sample(32'hD2, 1'b0);
        tick();
        chk("d_nwr", 64'(wr_cnt - base), 64'd1);

        // Reset mid-POST drops the in-flight write
        post_len = 9'd5;
        pulse_arm();
        base = wr_cnt;
        sample(32'hE0, 1'b1);
        sample(32'hE1, 1'b0);
        chk("e_inflight", write2, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("e_rst_write2", {write2, chipselect2}, 2'b00);
        chk("e_rst_status", {busy, done}, 2'b00);
        chk("e_rst_clken2", clken2, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();
        chk("e_nwr", 64'(wr_cnt - base), 64'd1);
        sample(32'hE2, 1'b1);
        tick();
        chk("e_idle_nwr", 64'(wr_cnt - base), 64'd1);
        chk("e_idle_busy", busy, 1'b0);

        // Decimation by 4, trigger on S5
        decim    = 8'd3;
        post_len = 9'd10;
        pulse_arm();
        base = wr_cnt;
        for (int k = 0; k < 12; k++) begin
            sample(32'h5000 + 32'(k), (k == 5));
        end
        tick();
`ifdef CURRCTRL_DBG_DECIM_EN
        chk("f_nwr", 64'(wr_cnt - base), 64'd3);
        chk("f_ram0", ram[0], 32'h5000);
        chk("f_ram1", ram[1], 32'h5004);
        chk("f_ram2", ram[2], 32'h5008);
        chk("f_trig_addr", trig_addr, 9'd2);
`else
        chk("f_nwr", 64'(wr_cnt - base), 64'd12);
        chk("f_ram5", ram[5], 32'h5005);
        chk("f_trig_addr", trig_addr, 9'd5);
`endif
        chk("f_busy", {busy, done}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_curr_ctrl_debug_capture
